// File: rtl/pattern_capture_if.sv
// rtl/pattern_capture_if.sv - control, sample input and output stream bundle for pattern_capture
interface pattern_capture_if #(
  parameter int WIDTH      = 2,
  parameter int ADDR_WIDTH = 3
);
  logic                  arm;
  logic                  trig;
  logic [WIDTH-1:0]      din;
  logic                  out_ready;
  logic                  busy;
  logic [ADDR_WIDTH:0]   count;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  done;

  // Environment side: drives controls, samples and consumer ready
  modport master (
    output arm, trig, din, out_ready,
    input  busy, count, out_valid, out_data, out_last, done
  );

  // Capture block side
  modport slave (
    input  arm, trig, din, out_ready,
    output busy, count, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/pattern_capture.sv
// rtl/pattern_capture.sv - step-timed capture buffer that streams captured samples out
module pattern_capture #(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int COUNT_WIDTH = 24,
  parameter int STEP_COUNTS = 6000000 - 1
) (
  input  logic              clk,
  input  logic              rst,
  pattern_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DUMP    = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] STEP_LAST  = COUNT_WIDTH'(STEP_COUNTS);
  localparam logic [ADDR_WIDTH:0]    COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]    COUNT_PREV = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                 state_q,     state_d;
  logic [ADDR_WIDTH:0]    count_q,     count_d;
  logic [COUNT_WIDTH-1:0] step_q,      step_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [WIDTH-1:0]       rd_data_q,   rd_data_d;
  logic                   rd_vld_q,    rd_vld_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q,  out_data_d;
  logic                   out_last_q,  out_last_d;
  logic                   done_q,      done_d;

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;
  logic [ADDR_WIDTH-1:0]  rd_ptr_nxt;

  // Sample memory is deliberately not reset; a capture rewrites every entry before the dump
  logic [WIDTH-1:0]       mem [DEPTH];

  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  // Next-state, step timing, memory write and output-stream sequencing
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    step_d      = step_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_vld_d    = rd_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = count_q[ADDR_WIDTH-1:0];
    mem_wdata   = bus.din;

    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_ARMED;
          count_d = '0;
        end
      end

      S_ARMED: begin
        // Sample 0 is taken on the trigger edge itself
        if (bus.trig) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          count_d   = (ADDR_WIDTH + 1)'(1);
          step_d    = '0;
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == COUNT_PREV) begin
            state_d  = S_DUMP;
            rd_ptr_d = '0;
            rd_vld_d = 1'b0;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      S_DUMP: begin
        if (out_valid_q) begin
          // The transfer edge also issues the next read, so valid drops for exactly one clock
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
              state_d  = S_IDLE;
              done_d   = 1'b1;
              rd_ptr_d = '0;
            end else begin
              rd_ptr_d  = rd_ptr_nxt;
              rd_data_d = mem[rd_ptr_nxt];
              rd_vld_d  = 1'b1;
            end
          end
        end else if (rd_vld_q) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data_q;
          out_last_d  = (rd_ptr_q == ADDR_LAST);
          rd_vld_d    = 1'b0;
        end else begin
          // First read of the dump, issued one edge after entering DUMP
          rd_data_d = mem[rd_ptr_q];
          rd_vld_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      step_q      <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_q      <= step_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_vld_q    <= rd_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Sample memory write port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.count     = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pattern_capture.sv
// tb/tb_pattern_capture.sv - randomized self-checking bench for pattern_capture
module tb_pattern_capture;
  localparam int WIDTH      = 2;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int STEP       = 4;

  logic clk = 1'b0;
  logic rst;

  pattern_capture_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  pattern_capture #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
    .COUNT_WIDTH(24), .STEP_COUNTS(STEP - 1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic [WIDTH-1:0] din_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // din_log[e] holds the din value present at clock edge e
  task automatic tick();
    din_log.push_back(bus.din);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  task automatic run_capture(input bit same_edge, input bit pat, input int stall_beat,
                             input bit noise, input bit rnd_rdy);
    int  e0, present_e, last_e, beat, stall_cnt, t, gap, exp_cnt, rel;
    bit  ended, exp_valid, xfer, hold, fin;
    logic [WIDTH-1:0] prev_data;
    bus.din       = WIDTH'($urandom);
    bus.arm       = 1'b1;
    bus.trig      = same_edge;
    bus.out_ready = 1'b1;
    tick();
    chk("armed_busy", bus.busy, 1);
    chk("armed_count", bus.count, 0);
    bus.arm = 1'b0;
    if (!same_edge) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        bus.din = WIDTH'($urandom);
        bus.arm = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk("armed_hold_count", bus.count, 0);
        chk("armed_hold_valid", bus.out_valid, 0);
      end
      bus.arm  = 1'b0;
      bus.trig = 1'b1;
    end
    e0        = cyc + 1;
    bus.din   = pat ? WIDTH'(0) : WIDTH'($urandom);
    present_e = e0 + (DEPTH - 1) * STEP + 2;
    last_e    = -1;
    beat      = 0;
    stall_cnt = 0;
    hold      = 1'b0;
    fin       = 1'b0;
    prev_data = '0;
    for (int n = 0; n < 600 && !fin; n++) begin
      tick();
      t         = cyc - e0;
      ended     = (last_e >= 0) && (cyc >= last_e);
      exp_valid = !ended && (cyc >= present_e);
      exp_cnt   = (t / STEP + 1 > DEPTH) ? DEPTH : t / STEP + 1;
      chk("count", bus.count, exp_cnt);
      chk("busy", bus.busy, !ended);
      chk("done", bus.done, ended && (cyc == last_e));
      chk("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) chk("out_last", bus.out_last, beat == DEPTH - 1);
      if (exp_valid && hold) chk("stall_stable", bus.out_data, prev_data);
      if (ended && cyc > last_e) begin
        fin = 1'b1;
      end else begin
        bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (exp_valid && beat == stall_beat && stall_cnt < 10) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
        end
        xfer = exp_valid && bus.out_ready;
        hold = exp_valid && !xfer;
        prev_data = bus.out_data;
        if (xfer) begin
          chk("beat_data", bus.out_data, din_log[e0 + beat * STEP]);
          if (pat) chk("pattern_data", bus.out_data, beat % 4);
          if (beat == DEPTH - 1) last_e = cyc + 1;
          else present_e = cyc + 2;
          beat++;
        end
        bus.arm  = noise && !ended && ($urandom_range(0, 3) == 0);
        bus.trig = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rel = cyc + 1 - e0;
        if (pat && (rel % STEP == 0)) bus.din = WIDTH'((rel / STEP) % 4);
        else bus.din = WIDTH'($urandom);
      end
    end
    chk("finished", fin, 1);
    bus.arm       = 1'b0;
    bus.trig      = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bus.arm       = 1'b0;
    bus.trig      = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    din_log.push_back('0);
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Reset in the middle of a capture, after three samples
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("mid_arm_busy", bus.busy, 1);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    repeat (2 * STEP) tick();
    chk("mid_count", bus.count, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    tick();
    rst = 1'b0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("rearm_busy", bus.busy, 1);
    chk("rearm_count", bus.count, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset2");

    run_capture(1'b0, 1'b1, -1, 1'b0, 1'b0);
    run_capture(1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_capture(1'b0, 1'b0, -1, 1'b1, 1'b0);
    run_capture(1'b1, 1'b0, -1, 1'b0, 1'b0);
    run_capture(1'b0, 1'b0, -1, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_capture(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, DEPTH - 1),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pattern_capture.md
# pattern_capture

Step-timed capture buffer: once armed and triggered, samples a WIDTH-bit input pattern every STEP_COUNTS+1 clocks into an internal DEPTH-entry memory, then streams the captured steps out over a valid/ready port. It records live patterns (e.g. LED or pattern-button states) at the same step rate the sequencer plays them back, and hands the sequence to a downstream consumer.

## Interface
- WIDTH, 2, bits per sample
- DEPTH, 8, samples per capture (power of two, ≥2)
- ADDR_WIDTH, 3, log2(DEPTH)
- COUNT_WIDTH, 24, step counter width
- STEP_COUNTS, 6000000-1, clocks between samples minus one
- clk  in  1  system clock (12 MHz)
- rst  in  1  reset; one clock, asynchronous, active-high
- arm  in  1  one-clock pulse; starts a capture from IDLE
- trig  in  1  level; capture starts on the first clk edge with trig=1 while ARMED
- din  in  WIDTH  pattern sampled at each step
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high when state ≠ IDLE
- count  out  ADDR_WIDTH+1  samples written this capture (0..DEPTH)
- out_valid  out  1  out_data holds a captured sample
- out_data  out  WIDTH  captured sample, address order 0..DEPTH-1
- out_last  out  1  high with the final sample (address DEPTH-1)
- done  out  1  one-clock pulse after the final transfer

## Operation
- States: IDLE, ARMED, CAPTURE, DUMP. Reset → IDLE.
- IDLE: arm=1 → ARMED, count←0. arm is ignored in every other state.
- ARMED: at the edge where trig=1, write din to mem[0], count←1, clear step counter, → CAPTURE.
- CAPTURE: step counter counts 0..STEP_COUNTS. When it reaches STEP_COUNTS, it wraps to 0, din is written to mem[count], and count increments. The write that makes count=DEPTH also sets state←DUMP. trig is ignored after the start.
- DUMP: read pointer starts at 0. Memory read is registered. out_valid/out_data/out_last assert one clock after the read is issued and hold stable until out_valid&out_ready.
  - After each transfer, out_valid=0 for exactly one clock, then the next sample is presented. Peak throughput is 1 word per 2 clocks.
  - The transfer with out_last=1 sets state←IDLE and gives done=1 for the next clock.
  - count holds DEPTH throughout DUMP and returns to 0 on the next arm.
- out_ready is ignored when out_valid=0. Holding out_ready low stalls indefinitely with data stable.
- Memory contents are not reset. A new capture overwrites all DEPTH entries before any are read.
- Reset at any time: immediate return to IDLE; pending data is discarded.

## Timing
- Reset values: busy=0, count=0, out_valid=0, out_data=0, out_last=0, done=0. Step counter and read pointer = 0.
- Edge E0 (trig seen): sample 0 uses din at E0.
- Sample k (k=1..DEPTH-1) uses din at edge E0 + k·(STEP_COUNTS+1). The state is DUMP after edge E0 + (DEPTH-1)·(STEP_COUNTS+1).
- out_valid first rises 2 edges after entry to DUMP: one edge to issue the read, one edge to register the data.
- busy rises the clock after arm and falls on the edge of the final transfer. done is high the clock after that edge.
- arm and trig both high in IDLE: the result is ARMED only. The trig is honoured on the next edge if it is still high.
- count width holds DEPTH without wrap. The write address uses count[ADDR_WIDTH-1:0].

## Test plan
- Reset mid-CAPTURE: after 3 samples, pulse rst → busy=0, count=0, out_valid=0 immediately. arm is then accepted normally.
- Basic capture (STEP_COUNTS=3, DEPTH=8, out_ready=1): arm, trig at E0, din = 0,1,2,3,0,1,2,3 at steps → out_data stream 0,1,2,3,0,1,2,3. out_last only on the 8th beat. done is a 1-clock pulse. Beats are 2 clocks apart.
- Step timing: same setup → count increments at E0, E0+4, …, E0+28. A din glitch between step edges is never captured.
- Backpressure: hold out_ready=0 for 10 clocks on beat 2 → out_data=1 stable with out_valid high. The stream resumes with no loss or duplication.
- Ignored controls: arm pulses during ARMED, CAPTURE, and DUMP → no restart, and count is unaffected. trig toggling in CAPTURE has no effect.
- Simultaneous arm+trig in IDLE → ARMED. trig held one more clock → sample 0 is taken at the second edge.
